// File: rtl/bus_sync_tx_sched.sv
// Transmit-side scheduler feeding a toggle-pulse bus synchronizer: buffers producer words
// and issues spaced single-cycle load pulses. Optional ack throttling via BUS_SYNC_TX_ACK_EN.
module bus_sync_tx_sched #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int GAP   = 6
) (
    input  logic                       a_clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
`ifdef BUS_SYNC_TX_ACK_EN
    input  logic                       b_ack_tgl,
`endif
    output logic                       in_ready,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       tx_ld_pls,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       busy
);

    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;
    localparam int GAP_EFF  = (GAP < 1) ? 1 : GAP;
    localparam int CW       = $clog2(GAP_EFF + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic [CW-1:0]      gap_cnt_r;
    logic [WIDTH-1:0]   tx_data_r;
    logic               tx_ld_pls_r;
    logic               push_s;
    logic               pop_s;
    logic               empty_s;
    logic               ack_ok_s;

    assign in_ready   = (level_r < LW'(DEPTH));
    assign empty_s    = (level_r == {LW{1'b0}});
    assign push_s     = in_valid && in_ready;
    // The pop happens on the edge entering LOAD so tx_data and the pulse rise together.
    assign pop_s      = (state_s == ST_LOAD);
    assign tx_data    = tx_data_r;
    assign tx_ld_pls  = tx_ld_pls_r;
    assign fifo_level = level_r;
    assign busy       = (state_r != ST_IDLE) || !empty_s;

`ifdef BUS_SYNC_TX_ACK_EN
    logic ack_s1_r;
    logic ack_s2_r;
    logic exp_ack_r;

    // Two-stage synchronizer for the receive-side ack toggle plus expected-ack tracker.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_s1_r  <= 1'b0;
            ack_s2_r  <= 1'b0;
            exp_ack_r <= 1'b0;
        end else begin
            ack_s1_r  <= b_ack_tgl;
            ack_s2_r  <= ack_s1_r;
            exp_ack_r <= pop_s ? ~exp_ack_r : exp_ack_r;
        end
    end

    assign ack_ok_s = (ack_s2_r == exp_ack_r);
`else
    assign ack_ok_s = 1'b1;
`endif

    // Next-state logic for the IDLE/LOAD/HOLD pulse scheduler.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) state_s = ST_LOAD;
                else          state_s = ST_IDLE;
            end
            ST_LOAD: state_s = ST_HOLD;
            ST_HOLD: begin
                if ((gap_cnt_r == {CW{1'b0}}) && ack_ok_s) begin
                    if (!empty_s) state_s = ST_LOAD;
                    else          state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge a_clk) begin
        if (push_s) mem_r[wr_ptr_r] <= in_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Gap counter: loaded during LOAD, counts down through HOLD.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_LOAD) begin
            gap_cnt_r <= GAP_LOAD;
        end else if ((state_r == ST_HOLD) && (gap_cnt_r != {CW{1'b0}})) begin
            gap_cnt_r <= gap_cnt_r - CW'(1);
        end
    end

    // Output registers: tx_data only moves with the load pulse.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_r   <= {WIDTH{1'b0}};
            tx_ld_pls_r <= 1'b0;
        end else begin
            if (pop_s) tx_data_r <= mem_r[rd_ptr_r];
            tx_ld_pls_r <= pop_s;
        end
    end

endmodule

// File: tb/tb_bus_sync_tx_sched.sv
// Directed self-checking bench for bus_sync_tx_sched (WIDTH=4, DEPTH=4).
module tb_bus_sync_tx_sched;

    localparam int W  = 4;
    localparam int D  = 4;
`ifdef BUS_SYNC_TX_ACK_EN
    localparam int G  = 2;
`else
    localparam int G  = 6;
`endif
    localparam int LW = $clog2(D) + 1;

    logic          a_clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  tx_data;
    logic          tx_ld_pls;
    logic [LW-1:0] fifo_level;
    logic          busy;
    logic          b_ack_tgl;
    logic          auto_ack;
    logic          prev_pls;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int            pulse_cyc[$];
    logic [W-1:0]  pulse_dat[$];

    bus_sync_tx_sched #(.WIDTH(W), .DEPTH(D), .GAP(G)) dut (
        .a_clk      (a_clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
`ifdef BUS_SYNC_TX_ACK_EN
        .b_ack_tgl  (b_ack_tgl),
`endif
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_ld_pls  (tx_ld_pls),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 a_clk = ~a_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge, log pulses and model the receiver ack.
    task automatic tick();
        @(posedge a_clk);
        #1;
        cyc++;
        if (tx_ld_pls) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(tx_data);
            chk("no_back_to_back", {31'd0, prev_pls}, 32'd0);
            if (auto_ack) b_ack_tgl = ~b_ack_tgl;
        end
        prev_pls = tx_ld_pls;
    endtask

    logic [W-1:0] words [6];
    logic [W-1:0] pw [4];
    logic         acc;
    logic         saw_full;
    int           i;
    int           n;

    initial begin
        words[0] = 4'h5; words[1] = 4'h6; words[2] = 4'h7;
        words[3] = 4'h8; words[4] = 4'h9; words[5] = 4'hB;
        pw[0] = 4'hC; pw[1] = 4'hD; pw[2] = 4'h1; pw[3] = 4'h2;

        // Reset with in_valid held high
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h3;
        b_ack_tgl = 1'b0;
        auto_ack  = 1'b1;
        prev_pls  = 1'b0;
        #2;
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_pls", 32'(tx_ld_pls), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        chk("rst_hold_level", 32'(fifo_level), 32'h0);
        chk("rst_hold_pls", 32'(tx_ld_pls), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("first_write_level", 32'(fifo_level), 32'h1);
        chk("first_cycle_no_pls", 32'(tx_ld_pls), 32'h0);
        in_valid = 1'b0;
        tick();
        chk("first_pls", 32'(tx_ld_pls), 32'h1);
        chk("first_data", 32'(tx_data), 32'h3);
        repeat (G + 4) tick();
        chk("first_drained", 32'(busy), 32'h0);

        // Single word 0xA: 2-cycle latency, one-cycle pulse, busy falls after HOLD
        in_valid = 1'b1;
        in_data  = 4'hA;
        tick();
        chk("single_level", 32'(fifo_level), 32'h1);
        chk("single_no_pls_yet", 32'(tx_ld_pls), 32'h0);
        in_valid = 1'b0;
        tick();
        chk("single_pls", 32'(tx_ld_pls), 32'h1);
        chk("single_data", 32'(tx_data), 32'hA);
        tick();
        chk("single_pls_low", 32'(tx_ld_pls), 32'h0);
        repeat (G - 2) tick();
        tick();
        chk("single_busy_hold", 32'(busy), 32'h1);
        tick();
        chk("single_busy_done", 32'(busy), 32'h0);
        chk("single_data_stable", 32'(tx_data), 32'hA);

        // Six words back-to-back: backpressure, order and exact spacing
        pulse_cyc.delete();
        pulse_dat.delete();
        i = 0;
        saw_full = 1'b0;
        for (int g = 0; g < 200 && i < 6; g++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            acc      = in_ready;
            tick();
            if (acc) i++;
            if (fifo_level == LW'(4) && !saw_full) begin
                saw_full = 1'b1;
                chk("full_in_ready", 32'(in_ready), 32'h0);
            end
            chk("level_bound", 32'(fifo_level <= LW'(4)), 32'h1);
        end
        in_valid = 1'b0;
        chk("saw_full", 32'(saw_full), 32'h1);
        chk("all_accepted", 32'(i), 32'd6);
        repeat (6 * (G + 1) + 10) tick();
        chk("six_pulse_count", 32'(pulse_dat.size()), 32'd6);
        for (int j = 0; j < 6 && j < pulse_dat.size(); j++) begin
            chk("six_order", 32'(pulse_dat[j]), 32'(words[j]));
            if (j > 0) chk("six_spacing", 32'(pulse_cyc[j] - pulse_cyc[j-1]), 32'(G + 1));
        end

        // Push coinciding with the pop at level 2
        pulse_cyc.delete();
        pulse_dat.delete();
        in_valid = 1'b1;
        in_data  = pw[0];
        tick();
        in_valid = 1'b0;
        tick();
        chk("lvl2_p0_pls", 32'(tx_ld_pls), 32'h1);
        in_valid = 1'b1;
        in_data  = pw[1];
        tick();
        in_data  = pw[2];
        tick();
        in_valid = 1'b0;
        repeat (G - 2) tick();
        chk("lvl2_before", 32'(fifo_level), 32'h2);
        chk("lvl2_no_pls", 32'(tx_ld_pls), 32'h0);
        in_valid = 1'b1;
        in_data  = pw[3];
        tick();
        in_valid = 1'b0;
        chk("lvl2_kept", 32'(fifo_level), 32'h2);
        chk("lvl2_pls", 32'(tx_ld_pls), 32'h1);
        chk("lvl2_data", 32'(tx_data), 32'(pw[1]));
        repeat (3 * (G + 1) + 4) tick();
        chk("lvl2_count", 32'(pulse_dat.size()), 32'd4);
        for (int j = 0; j < 4 && j < pulse_dat.size(); j++)
            chk("lvl2_order", 32'(pulse_dat[j]), 32'(pw[j]));

        // Reset asserted mid-HOLD with 3 words buffered
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 4'(j + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("midrst_level_before", 32'(fifo_level), 32'h3);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        reset_n   = 1'b0;
        b_ack_tgl = 1'b0;
        #1;
        chk("midrst_level", 32'(fifo_level), 32'h0);
        chk("midrst_pls", 32'(tx_ld_pls), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        tick();
        tick();
        reset_n = 1'b1;
        pulse_cyc.delete();
        pulse_dat.delete();
        repeat (20) tick();
        chk("midrst_no_pulse", 32'(pulse_dat.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'h0);
        in_valid = 1'b1;
        in_data  = 4'hE;
        tick();
        in_valid = 1'b0;
        tick();
        chk("postrst_pls", 32'(tx_ld_pls), 32'h1);
        chk("postrst_data", 32'(tx_data), 32'hE);
        repeat (G + 4) tick();

`ifdef BUS_SYNC_TX_ACK_EN
        // Ack withheld: only one pulse until the receiver toggles
        auto_ack = 1'b0;
        pulse_cyc.delete();
        pulse_dat.delete();
        in_valid = 1'b1;
        in_data  = 4'h6;
        tick();
        in_data  = 4'h9;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("ack_one_pulse", 32'(pulse_dat.size()), 32'd1);
        b_ack_tgl = ~b_ack_tgl;
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_ld_pls && n < 10);
        chk("ack_latency", 32'(n), 32'd3);
        chk("ack_data", 32'(tx_data), 32'h9);
        b_ack_tgl = ~b_ack_tgl;
        repeat (10) tick();
        chk("ack_drained", 32'(busy), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
